// File: rtl/seq_scaled_divider.sv
// seq_scaled_divider: multi-cycle restoring divider computing trunc((dividend <<< IN_SCALE) / divisor), saturated
module seq_scaled_divider #(
    parameter int DIVIDEND_WIDTH = 16,
    parameter int DIVISOR_WIDTH  = 8,
    parameter int IN_SCALE       = 0,
    parameter int QUOTIENT_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [DIVIDEND_WIDTH-1:0] dividend,
    input  logic signed [DIVISOR_WIDTH-1:0]  divisor,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [QUOTIENT_WIDTH-1:0] quotient,
    output logic                             saturated,
    output logic                             div_by_zero
);
    localparam int DW = DIVIDEND_WIDTH;
    localparam int BW = DIVISOR_WIDTH;
    localparam int QW = QUOTIENT_WIDTH;
    localparam int W  = DW + IN_SCALE;
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0]  W_POS_LIM = W'(2 ** (QW - 1) - 1);
    localparam logic [W-1:0]  W_NEG_LIM = W'(2 ** (QW - 1));
    localparam logic [QW-1:0] Q_MAX     = {1'b0, {(QW - 1){1'b1}}};
    localparam logic [QW-1:0] Q_MIN     = {1'b1, {(QW - 1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIN, S_DONE} state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [BW-1:0]   r_b;
    logic [BW-1:0]   r_rem;
    logic [CW-1:0]   r_cnt;
    logic            r_sa;
    logic            r_sb;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [QW-1:0]   r_q;
    logic            r_sat;
    logic            r_dbz;

    // Two's-complement negation in the operand width yields the exact unsigned
    // magnitude, including for the most negative value.
    logic [DW-1:0]   w_a_abs;
    logic [BW-1:0]   w_b_abs;
    logic [W-1:0]    w_a_sh;
    logic [BW:0]     w_rs;
    logic            w_ge;
    logic [BW-1:0]   w_sub;
    logic [QW-1:0]   w_qmag;
    logic            w_neg;
    logic            w_sat_pos;
    logic            w_sat_neg;

    assign w_a_abs   = dividend[DW-1] ? $unsigned(-dividend) : $unsigned(dividend);
    assign w_b_abs   = divisor[BW-1] ? $unsigned(-divisor) : $unsigned(divisor);
    assign w_a_sh    = W'(w_a_abs) << IN_SCALE;
    // r_a doubles as dividend shifter and quotient collector: dividend bits
    // leave at the top while quotient bits enter at the bottom.
    assign w_rs      = {r_rem, r_a[W-1]};
    assign w_ge      = w_rs >= {1'b0, r_b};
    assign w_sub     = w_rs[BW-1:0] - r_b;
    assign w_qmag    = r_a[QW-1:0];
    assign w_neg     = r_sa ^ r_sb;
    assign w_sat_pos = r_a > W_POS_LIM;
    assign w_sat_neg = r_a > W_NEG_LIM;

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_q;
    assign saturated   = r_sat;
    assign div_by_zero = r_dbz;

    // Control FSM: capture, W restoring steps, sign/saturation fixup, then hold result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_q         <= '0;
            r_sat       <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_a        <= w_a_sh;
                    r_b        <= w_b_abs;
                    r_sa       <= dividend[DW-1];
                    r_sb       <= divisor[BW-1];
                    r_rem      <= '0;
                    r_cnt      <= CW'(W);
                    r_in_ready <= 1'b0;
                    r_state    <= (divisor == '0) ? S_FIN : S_DIV;
                end
                S_DIV: begin
                    r_rem   <= w_ge ? w_sub : w_rs[BW-1:0];
                    r_a     <= {r_a[W-2:0], w_ge};
                    r_cnt   <= r_cnt - CW'(1);
                    r_state <= (r_cnt == CW'(1)) ? S_FIN : S_DIV;
                end
                S_FIN: begin
                    r_state     <= S_DONE;
                    r_out_valid <= 1'b1;
                    r_dbz       <= (r_b == '0);
                    r_sat       <= (r_b == '0) ? 1'b1 : (w_neg ? w_sat_neg : w_sat_pos);
                    r_q         <= (r_b == '0) ? (r_sa ? Q_MIN : Q_MAX) :
                                   w_neg ? (w_sat_neg ? Q_MIN : -w_qmag) :
                                           (w_sat_pos ? Q_MAX : w_qmag);
                end
                S_DONE: if (out_ready) begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
